riscv_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the RISC-V datapath decode. Owns the program counter and issues in-order word reads to instruction memory over a valid/ready request channel. Buffers returned instructions with their PCs in a small queue feeding decode. Accepts a single-cycle redirect from execute (taken branch/jump, e.g. `bne`) that flushes all fetched-but-unconsumed work.

---
 rtl/riscv_fetch_pkg.sv | 17 +
 rtl/riscv_fetch_instr_fifo.sv | 58 +++++
 rtl/riscv_fetch.sv | 108 ++++++++++
 tb/tb_riscv_fetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared constants and types for the instruction fetch stage
package riscv_fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Counters must represent 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/riscv_fetch_instr_fifo.sv
// rtl/riscv_fetch_instr_fifo.sv - synchronous FIFO with flush, power-of-two depth
module riscv_fetch_instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - RISC-V fetch stage: PC, credit-limited imem requests, instruction queue
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc
);

  localparam int unsigned CW = credit_width(QDEPTH);

  logic [31:0]  r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [31:0]  w_redirect_pc;
  logic [CW:0]  w_inflight;
  logic         w_req_fire;
  logic         w_rsp_ok;
  logic         w_rsp_live;
  logic         w_q_push;
  logic         w_q_pop;
  logic [31:0]  w_rsp_pc;
  logic [CW-1:0] w_pc_count;
  logic [CW-1:0] w_q_count;
  fetch_entry_t w_q_head;
  fetch_entry_t w_q_wdata;

  assign w_redirect_pc = i_redirect_pc & ~32'h3;

  // Credits cover both in-flight requests and buffered words so the queue never overflows.
  assign w_inflight       = {1'b0, r_outstanding} + {1'b0, w_q_count};
  assign o_imem_req_valid = !i_rst && !i_redirect && (w_inflight < (CW+1)'(QDEPTH));
  assign o_imem_addr      = r_fetch_pc;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;

  // Responses with nothing outstanding are stray (e.g. issued before reset) and ignored.
  assign w_rsp_ok   = i_imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_live = w_rsp_ok && (r_drop == '0) && (w_pc_count != '0);
  assign w_q_push   = w_rsp_live && !i_redirect;
  assign w_q_pop    = o_instr_valid && i_instr_ready;

  assign w_q_wdata.pc   = w_rsp_pc;
  assign w_q_wdata.word = i_imem_rsp_data;

  assign o_instr_valid = (w_q_count != '0);
  assign o_instr       = o_instr_valid ? w_q_head.word : 32'h0;
  assign o_instr_pc    = o_instr_valid ? w_q_head.pc   : 32'h0;

  riscv_fetch_instr_fifo #(
    .WIDTH (32),
    .DEPTH (QDEPTH)
  ) u_pc_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (w_req_fire),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_rsp_live),
    .o_rdata (w_rsp_pc),
    .o_count (w_pc_count)
  );

  riscv_fetch_instr_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_instr_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (w_q_push),
    .i_wdata (w_q_wdata),
    .i_pop   (w_q_pop),
    .o_rdata (w_q_head),
    .o_count (w_q_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (i_redirect) begin
      // Everything still in flight belongs to the squashed path.
      r_fetch_pc    <= w_redirect_pc;
      r_outstanding <= r_outstanding - CW'(w_rsp_ok);
      r_drop        <= r_outstanding - CW'(w_rsp_ok);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
      if (w_rsp_ok && (r_drop != '0)) r_drop <= r_drop - 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb/tb_riscv_fetch.sv - self-checking bench for riscv_fetch with memory model and scoreboard
module tb_riscv_fetch;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } del_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        req_valid;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        req_valid2;
  logic [31:0] imem_addr2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;

  riscv_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (imem_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc)
  );

  riscv_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut2 (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (req_valid2),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (imem_addr2),
    .i_imem_rsp_valid (1'b0),
    .i_imem_rsp_data  (32'h0),
    .i_redirect       (1'b0),
    .i_redirect_pc    (32'h0),
    .o_instr_valid    (instr_valid2),
    .i_instr_ready    (1'b0),
    .o_instr          (instr2),
    .o_instr_pc       (instr_pc2)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          lat = 1;
  int          t0;
  bit          ready_ctl = 0;
  bit          iready_ctl = 0;
  bit          redir_req = 0;
  bit          prev_redir = 0;
  logic [31:0] redir_pc_req = 32'h0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] e;
  logic [31:0] exp2 [3];
  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  del_t        del_log[$];
  logic [31:0] addr2_log[$];
  vec_t        vecs [5];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_q[0].addr | 32'hA000_0000;
      void'(mem_q.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
    redirect    = redir_req;
    redirect_pc = redir_pc_req;
    req_ready   = ready_ctl;
    instr_ready = iready_ctl;
    #1;
    if (redirect) chk(req_valid == 1'b0, "redirect_req_low", {31'h0, req_valid}, 32'h0);
    if (prev_redir) chk(instr_valid == 1'b0, "post_redirect_instr_valid", {31'h0, instr_valid}, 32'h0);
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_instr", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk(instr_pc == e, "instr_pc", instr_pc, e);
        chk(instr == (e | 32'hA000_0000), "instr_word", instr, e | 32'hA000_0000);
      end
      del_log.push_back('{pc: instr_pc, cyc: cyc});
    end
    if (req_valid && req_ready) begin
      chk(imem_addr == model_pc, "imem_addr", imem_addr, model_pc);
      mem_q.push_back('{addr: model_pc, due: cyc + lat});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
      n_acc++;
    end
    if (req_valid2 && req_ready && addr2_log.size() < 3) addr2_log.push_back(imem_addr2);
    if (redirect) begin
      exp_q.delete();
      model_pc = redirect_pc & ~32'h3;
    end
    prev_redir = redirect;
    redir_req  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    vecs[0] = '{rpc: 32'h0000_0043, exp_addr: 32'h0000_0040};
    vecs[1] = '{rpc: 32'h0000_0200, exp_addr: 32'h0000_0200};
    vecs[2] = '{rpc: 32'h0000_1001, exp_addr: 32'h0000_1000};
    vecs[3] = '{rpc: 32'h0000_0006, exp_addr: 32'h0000_0004};
    vecs[4] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;

    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk(req_valid == 1'b0, "rst_req_valid", {31'h0, req_valid}, 32'h0);
    chk(instr_valid == 1'b0, "rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk(instr == 32'h0, "rst_instr", instr, 32'h0);
    chk(instr_pc == 32'h0, "rst_instr_pc", instr_pc, 32'h0);
    chk(imem_addr == 32'h0, "rst_imem_addr", imem_addr, 32'h0);
    chk(imem_addr2 == 32'hFFFF_FFF8, "rst_imem_addr2", imem_addr2, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(req_valid == 1'b1, "first_req_valid", {31'h0, req_valid}, 32'h1);

    // Streaming at one instruction per cycle with single-cycle memory.
    ready_ctl = 1; iready_ctl = 1; lat = 1; t0 = cyc + 1;
    del_log.delete();
    run(12);
    chk(del_log.size() >= 4, "stream_count", del_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < del_log.size(); i++) begin
      chk(del_log[i].pc == 32'(4 * i), "stream_pc", del_log[i].pc, 32'(4 * i));
      chk(del_log[i].cyc == t0 + 2 + i, "stream_cycle", del_log[i].cyc, t0 + 2 + i);
    end
    chk(addr2_log.size() == 3, "wrap_count", addr2_log.size(), 32'd3);
    for (int i = 0; i < 3 && i < addr2_log.size(); i++)
      chk(addr2_log[i] == exp2[i], "wrap_addr", addr2_log[i], exp2[i]);

    // Decode stalled: credit limit caps requests at QDEPTH.
    iready_ctl = 0; redir_req = 1; redir_pc_req = 32'h0;
    run(1);
    n_acc = 0;
    run(10);
    chk(n_acc == 4, "stall_req_count", n_acc, 32'd4);
    chk(req_valid == 1'b0, "stall_req_low", {31'h0, req_valid}, 32'h0);
    del_log.delete();
    iready_ctl = 1;
    run(8);
    chk(del_log.size() >= 5, "release_count", del_log.size(), 32'd5);
    for (int i = 0; i < 5 && i < del_log.size(); i++)
      chk(del_log[i].pc == 32'(4 * i), "release_pc", del_log[i].pc, 32'(4 * i));

    // Redirect with late responses still in flight.
    lat = 3; redir_req = 1; redir_pc_req = 32'h0;
    run(1);
    run(2);
    redir_req = 1; redir_pc_req = 32'h40;
    del_log.delete();
    run(15);
    chk(del_log.size() > 0, "late_redirect_count", del_log.size(), 32'd1);
    if (del_log.size() > 0) chk(del_log[0].pc == 32'h40, "late_redirect_first_pc", del_log[0].pc, 32'h40);
    foreach (del_log[i]) chk(del_log[i].pc >= 32'h40, "late_redirect_no_stale", del_log[i].pc, 32'h40);

    // Redirect target alignment table.
    lat = 1;
    foreach (vecs[v]) begin
      redir_req = 1; redir_pc_req = vecs[v].rpc;
      run(1);
      del_log.delete();
      run(1);
      chk(imem_addr == vecs[v].exp_addr, "redirect_addr", imem_addr, vecs[v].exp_addr);
      chk(req_valid == 1'b1, "redirect_next_req", {31'h0, req_valid}, 32'h1);
      run(6);
      if (del_log.size() > 0)
        chk(del_log[0].pc == vecs[v].exp_addr, "redirect_first_pc", del_log[0].pc, vecs[v].exp_addr);
      else
        chk(1'b0, "redirect_first_pc_missing", 32'h0, vecs[v].exp_addr);
    end

    // Reset in the middle of traffic, then a stray response.
    lat = 2; iready_ctl = 0; redir_req = 1; redir_pc_req = 32'h0;
    run(1);
    run(3);
    rst = 1'b1;
    #1;
    chk(instr_valid == 1'b0, "midrst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk(imem_addr == 32'h0, "midrst_imem_addr", imem_addr, 32'h0);
    chk(req_valid == 1'b0, "midrst_req_valid", {31'h0, req_valid}, 32'h0);
    mem_q.delete(); exp_q.delete(); model_pc = 32'h0; prev_redir = 0;
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    rst = 1'b0;
    ready_ctl = 0; iready_ctl = 1;
    mem_q.push_back('{addr: 32'h0000_0770, due: cyc + 1});
    del_log.delete();
    run(2);
    chk(instr_valid == 1'b0, "stray_dropped", {31'h0, instr_valid}, 32'h0);
    ready_ctl = 1;
    run(8);
    if (del_log.size() > 0) chk(del_log[0].pc == 32'h0, "post_rst_first_pc", del_log[0].pc, 32'h0);
    else chk(1'b0, "post_rst_first_pc_missing", 32'h0, 32'h0);
    chk(instr_valid2 == 1'b0, "idle_dut_instr_valid", {31'h0, instr_valid2}, 32'h0);
    chk(instr2 == 32'h0 && instr_pc2 == 32'h0, "idle_dut_instr", instr2 | instr_pc2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
